multi_core_nonce_dispatcher: RTL and testbench

Parametrised successor to the single-core miner datapath: fans one nonce search out across NUM_CORES SHA cores in parallel batches. Dispatches consecutive nonces to each core and collects completions. Compares each hash against the target and reports the first winning nonce, or exhaustion of the nonce space. Sits between the Avalon slave register bank and an array of SHA computational blocks; supersedes the old controller, nonce generator and comparator triple.

---
 rtl/miner_pkg.sv | 17 +
 rtl/multi_core_nonce_dispatcher_if.sv | 38 +++
 rtl/priority_hit_encoder.sv | 21 ++
 rtl/multi_core_nonce_dispatcher.sv | 116 +++++++++++
 tb/tb_multi_core_nonce_dispatcher.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// Shared types for the nonce dispatcher: FSM state encoding and core index width helper.
package miner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT,
    FOUND,
    EXHAUSTED
  } state_t;

  // A single-core build still needs a 1-bit index port.
  function automatic int CORE_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_core_nonce_dispatcher_if.sv
// Bundle between the register bank / SHA core array and the nonce dispatcher.
interface multi_core_nonce_dispatcher_if
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256
);
  localparam int IDX_W = CORE_IDX_W(NUM_CORES);

  logic                           start;
  logic                           abort;
  logic [HASH_W-1:0]              target;
  logic [NUM_CORES-1:0]           core_begin;
  logic [NUM_CORES*NONCE_W-1:0]   core_nonce;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES*HASH_W-1:0]    core_hash;
  logic                           busy;
  logic                           found;
  logic                           exhausted;
  logic [NONCE_W-1:0]             found_nonce;
  logic [IDX_W-1:0]               found_core;
  logic [NONCE_W-1:0]             batch_count;

  // master: software side plus the core array; slave: the dispatcher itself.
  modport master (
    output start, abort, target, core_done, core_hash,
    input  core_begin, core_nonce, busy, found, exhausted,
           found_nonce, found_core, batch_count
  );

  modport slave (
    input  start, abort, target, core_done, core_hash,
    output core_begin, core_nonce, busy, found, exhausted,
           found_nonce, found_core, batch_count
  );

endinterface

// File: rtl/priority_hit_encoder.sv
// Lowest-index-wins encoder over a hit vector, with an any-hit flag.
module priority_hit_encoder
  import miner_pkg::*;
#(
  parameter int  NUM_CORES = 4,
  localparam int IDX_W     = CORE_IDX_W(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] hit,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    any = |hit;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/multi_core_nonce_dispatcher.sv
// Fans a nonce search across NUM_CORES SHA cores in lock-step batches and reports
// the first winning nonce (lowest core index within a batch) or nonce-space exhaustion.
module multi_core_nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int          NUM_CORES   = 4,
  parameter int          NONCE_W     = 32,
  parameter int          HASH_W      = 256,
  parameter int unsigned NONCE_START = 0,
  localparam int         IDX_W       = CORE_IDX_W(NUM_CORES)
) (
  input logic                          clk,
  input logic                          rst,
  multi_core_nonce_dispatcher_if.slave bus
);

  state_t                       state;
  logic [NONCE_W-1:0]           base;
  logic                         last_batch;
  logic [NUM_CORES-1:0]         done_mask;
  logic [NUM_CORES-1:0]         hit_mask;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce;
  logic [NONCE_W-1:0]           batch_count;
  logic [NONCE_W-1:0]           found_nonce;
  logic [IDX_W-1:0]             found_core;

  logic [NUM_CORES-1:0]         hit_cmp;
  logic [NUM_CORES-1:0]         fresh;
  logic [NUM_CORES-1:0]         hit_next;
  logic                         all_done;
  logic [IDX_W-1:0]             hit_idx;
  logic                         hit_any;
  logic [NONCE_W:0]             base_sum;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_cmp
    assign hit_cmp[i] = bus.core_hash[i*HASH_W +: HASH_W] < bus.target;
  end

  // Only the first completion of a core in a batch may update its hit bit.
  assign fresh    = bus.core_done & ~done_mask;
  assign hit_next = (fresh & hit_cmp) | (~fresh & hit_mask);
  assign all_done = &(done_mask | bus.core_done);
  assign base_sum = {1'b0, base} + (NONCE_W+1)'(NUM_CORES);

  priority_hit_encoder #(.NUM_CORES(NUM_CORES)) u_enc (
    .hit (hit_next),
    .idx (hit_idx),
    .any (hit_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      last_batch  <= 1'b0;
      done_mask   <= '0;
      hit_mask    <= '0;
      core_nonce  <= '0;
      batch_count <= '0;
      found_nonce <= '0;
      found_core  <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (bus.start) begin
            base        <= NONCE_W'(NONCE_START);
            batch_count <= '0;
            found_nonce <= '0;
            found_core  <= '0;
            state       <= DISPATCH;
          end
        end
        DISPATCH: begin
          for (int i = 0; i < NUM_CORES; i++) begin
            core_nonce[i*NONCE_W +: NONCE_W] <= base + NONCE_W'(i);
          end
          base        <= base_sum[NONCE_W-1:0];
          last_batch  <= base_sum[NONCE_W];
          batch_count <= batch_count + 1'b1;
          done_mask   <= '0;
          hit_mask    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          done_mask <= done_mask | bus.core_done;
          hit_mask  <= hit_next;
          if (all_done) begin
            // A hit in the final batch still reports FOUND rather than EXHAUSTED.
            if (hit_any) begin
              found_core  <= hit_idx;
              found_nonce <= core_nonce[hit_idx*NONCE_W +: NONCE_W];
              state       <= FOUND;
            end else if (last_batch) begin
              state <= EXHAUSTED;
            end else begin
              state <= DISPATCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_begin  = {NUM_CORES{(state == DISPATCH) && !bus.abort}};
  assign bus.core_nonce  = core_nonce;
  assign bus.busy        = (state == DISPATCH) || (state == WAIT);
  assign bus.found       = (state == FOUND);
  assign bus.exhausted   = (state == EXHAUSTED);
  assign bus.found_nonce = found_nonce;
  assign bus.found_core  = found_core;
  assign bus.batch_count = batch_count;

endmodule

// File: tb/tb_multi_core_nonce_dispatcher.sv
// Directed bench for the nonce dispatcher: 4 cores, 8-bit nonces, 16-bit hashes.
module tb_multi_core_nonce_dispatcher;

  localparam int NC = 4;
  localparam int NW = 8;
  localparam int HW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   begin_cnt = 0;

  always #5 clk = ~clk;

  multi_core_nonce_dispatcher_if #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) bus ();

  multi_core_nonce_dispatcher #(
    .NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW), .NONCE_START(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.core_begin != '0) begin_cnt++;

  typedef struct {
    logic [63:0] hs;        // hash of core i in hs[i*16 +: 16]
    logic [7:0]  ord;       // k-th completing core in ord[k*2 +: 2]
    logic [15:0] tgt;
    logic [1:0]  exp_core;
    logic [7:0]  exp_nonce;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse(input int c, input logic [15:0] h);
    bus.core_hash[c*16 +: 16] = h;
    bus.core_done = 4'(1 << c);
    tick();
    bus.core_done = '0;
  endtask

  task automatic run_batch(input logic [63:0] hs, input logic [7:0] ord);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = int'(ord[k*2 +: 2]);
      pulse(c, hs[c*16 +: 16]);
    end
  endtask

  localparam logic [63:0] NOHIT = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [7:0]  ORD_0123 = {2'd3, 2'd2, 2'd1, 2'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bc0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.target = '0;
    bus.core_done = '0;
    bus.core_hash = '0;

    vecs[0] = '{{16'hF000, 16'h0050, 16'h0100, 16'h9000}, {2'd2, 2'd1, 2'd0, 2'd3}, 16'h0200, 2'd1, 8'h01};
    vecs[1] = '{{16'h0001, 16'h0002, 16'h0003, 16'h0004}, {2'd0, 2'd1, 2'd2, 2'd3}, 16'h0200, 2'd0, 8'h00};
    vecs[2] = '{{16'h01FF, 16'hFFFF, 16'h0200, 16'h0200}, ORD_0123,                   16'h0200, 2'd3, 8'h03};
    vecs[3] = '{{16'h0001, 16'h0000, 16'hFFFF, 16'h0001}, {2'd3, 2'd0, 2'd1, 2'd2}, 16'h0001, 2'd2, 8'h02};

    // Reset state
    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_found", bus.found, 0);
    check("rst_exh", bus.exhausted, 0);
    check("rst_begin", bus.core_begin, 0);
    check("rst_nonce", bus.core_nonce, 0);
    check("rst_bcount", bus.batch_count, 0);
    rst = 1'b0;

    // Single-batch hits, first from IDLE then restarting from FOUND
    for (int v = 0; v < 4; v++) begin
      bus.target = vecs[v].tgt;
      bc0 = begin_cnt;
      do_start();
      check($sformatf("v%0d_begin", v), bus.core_begin, 4'hF);
      tick();
      check($sformatf("v%0d_nonces", v), bus.core_nonce, 32'h0302_0100);
      run_batch(vecs[v].hs, vecs[v].ord);
      check($sformatf("v%0d_found", v), bus.found, 1);
      check($sformatf("v%0d_exh", v), bus.exhausted, 0);
      check($sformatf("v%0d_busy", v), bus.busy, 0);
      check($sformatf("v%0d_core", v), bus.found_core, vecs[v].exp_core);
      check($sformatf("v%0d_fnonce", v), bus.found_nonce, vecs[v].exp_nonce);
      check($sformatf("v%0d_bcount", v), bus.batch_count, 1);
      check($sformatf("v%0d_npulse", v), begin_cnt - bc0, 1);
    end

    // Multi-batch search, hit on core 2 of batch 3
    bus.target = 16'h0200;
    do_start();
    tick();
    run_batch(NOHIT, ORD_0123);
    check("mb_begin2", bus.core_begin, 4'hF);
    check("mb_found_early", bus.found, 0);
    tick();
    check("mb_nonce2", bus.core_nonce, 32'h0706_0504);
    run_batch(NOHIT, {2'd0, 2'd1, 2'd2, 2'd3});
    check("mb_begin3", bus.core_begin, 4'hF);
    tick();
    run_batch({16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF}, ORD_0123);
    check("mb_found", bus.found, 1);
    check("mb_fnonce", bus.found_nonce, 8'h0A);
    check("mb_core", bus.found_core, 2);
    check("mb_bcount", bus.batch_count, 3);

    // Exhaustion of the whole 8-bit nonce space
    do_start();
    tick();
    for (int b = 0; b < 64; b++) begin
      run_batch(NOHIT, ORD_0123);
      if (b < 63) tick();
    end
    check("ex_exh", bus.exhausted, 1);
    check("ex_found", bus.found, 0);
    check("ex_busy", bus.busy, 0);
    check("ex_nonce", bus.core_nonce, 32'hFFFE_FDFC);
    check("ex_bcount", bus.batch_count, 64);

    // Hit in the final batch beats exhaustion
    do_start();
    tick();
    for (int b = 0; b < 64; b++) begin
      run_batch((b == 63) ? {16'h0010, 48'hFFFF_FFFF_FFFF} : NOHIT, ORD_0123);
      if (b < 63) tick();
    end
    check("fb_found", bus.found, 1);
    check("fb_exh", bus.exhausted, 0);
    check("fb_fnonce", bus.found_nonce, 8'hFF);
    check("fb_core", bus.found_core, 3);

    // Abort with simultaneous start mid-WAIT
    do_start();
    tick();
    pulse(0, 16'hFFFF);
    pulse(1, 16'hFFFF);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("ab_busy", bus.busy, 0);
    check("ab_found", bus.found, 0);
    check("ab_nonce_kept", bus.core_nonce, 32'h0302_0100);
    bc0 = begin_cnt;
    pulse(2, 16'h0000);
    pulse(3, 16'h0000);
    tick();
    check("ab_late_busy", bus.busy, 0);
    check("ab_late_found", bus.found, 0);
    check("ab_late_begin", begin_cnt - bc0, 0);

    // Abort during the dispatch cycle suppresses the begin pulse
    do_start();
    bus.abort = 1'b1;
    #1;
    check("abd_begin", bus.core_begin, 0);
    tick();
    bus.abort = 1'b0;
    check("abd_busy", bus.busy, 0);
    check("abd_bcount", bus.batch_count, 0);

    // Reset mid-WAIT of batch 2, then stray completions
    do_start();
    tick();
    run_batch(NOHIT, ORD_0123);
    tick();
    pulse(0, 16'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_busy", bus.busy, 0);
    check("rw_nonce", bus.core_nonce, 0);
    check("rw_bcount", bus.batch_count, 0);
    check("rw_fnonce", bus.found_nonce, 0);
    check("rw_fcore", bus.found_core, 0);
    pulse(1, 16'h0000);
    pulse(2, 16'h0000);
    pulse(3, 16'h0000);
    check("rw_idle_busy", bus.busy, 0);
    check("rw_idle_found", bus.found, 0);
    check("rw_idle_begin", bus.core_begin, 0);

    // Duplicate completion does not finish the batch early nor set a hit
    do_start();
    tick();
    pulse(0, 16'hFFFF);
    pulse(0, 16'h0000);
    pulse(1, 16'hFFFF);
    pulse(2, 16'hFFFF);
    check("dup_busy", bus.busy, 1);
    check("dup_no_early", bus.core_begin, 0);
    pulse(3, 16'hFFFF);
    check("dup_begin", bus.core_begin, 4'hF);
    check("dup_found", bus.found, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("dup_abort_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
